// File: rtl/gpu_pkg.sv
// Shared constants for the GPU command sequencer: command map, control
// opcodes, writer FSM state type and performance counter count.
package gpu_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_BASE   = 8'h01;
    localparam logic [7:0] ADDR_STRIDE = 8'h02;
    localparam logic [3:0] REG_PAGE    = 4'h1;

    localparam logic [3:0] OP_START_RASTER = 4'd0;
    localparam logic [3:0] OP_START_WRITE  = 4'd2;
    localparam logic [3:0] OP_WAIT_FLUSH   = 4'd4;
    localparam logic [3:0] OP_RESET_STATE  = 4'd5;
    localparam logic [3:0] OP_FENCE        = 4'd6;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_LAUNCH = 2'd1,
        W_BUSY   = 2'd2
    } wr_state_e;

    localparam int NUM_PERF = 5;

endpackage

// File: rtl/gpu_idx_fifo.sv
// Small circular FIFO of tile-buffer indices awaiting the tile writer.
// Push while full and pop while empty are ignored.
module gpu_idx_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage: data only, no reset needed since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// GPU command sequencer: decodes the command stream, dispatches raster units
// round-robin, rotates tile buffers and drives the tile writer.
// Optional performance counters are built only when GPU_PERF_COUNTERS_EN is
// defined; otherwise perf_data is tied to zero.
//
// Writer FSM
//   state    | meaning
//   W_IDLE   | no write in flight; launches the queue head when one is pending
//   W_LAUNCH | wr_start issued, waiting for the writer to raise wr_reading
//   W_BUSY   | writer reading the tile buffer, waiting for wr_reading to drop
module gpu_cmd_sequencer
    import gpu_pkg::*;
#(
    parameter int  NUM_RASTER = 2,
    parameter int  NUM_BUF    = 3,
    parameter int  CNT_W      = 32,
    localparam int BW         = $clog2(NUM_BUF)
) (
    input  logic                       gpu_clk,
    input  logic                       gpu_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_addr,
    input  logic [31:0]                cmd_data,
    output logic [NUM_RASTER-1:0]      raster_start,
    input  logic [NUM_RASTER-1:0]      raster_busy,
    output logic [NUM_RASTER*BW-1:0]   raster_buf,
    output logic                       raster_clear,
    output logic                       reg_wren,
    output logic [3:0]                 reg_addr,
    output logic [31:0]                reg_data,
    output logic                       wr_start,
    output logic [BW-1:0]              wr_buf,
    input  logic                       wr_reading,
    input  logic                       wr_flushed,
    output logic [31:0]                addr_out,
    output logic [15:0]                stride_out,
    input  logic [2:0]                 perf_sel,
    output logic [CNT_W-1:0]           perf_data
);

    localparam int RW = (NUM_RASTER > 1) ? $clog2(NUM_RASTER) : 1;

    logic [BW-1:0]            fill_q, fill_d;
    logic [RW-1:0]            rr_q, rr_d;
    logic [NUM_RASTER-1:0]    rstart_q, rstart_d;
    logic [NUM_RASTER*BW-1:0] rbuf_q, rbuf_d;
    logic                     clear_q, clear_d;
    logic                     wren_q, wren_d;
    logic [3:0]               raddr_q, raddr_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [31:0]              addr_q, addr_d;
    logic [15:0]              stride_q, stride_d;
    logic                     wr_start_q, wr_start_d;
    logic [BW-1:0]            wr_buf_q, wr_buf_d;
    wr_state_e                wstate_q, wstate_d;

    logic          is_ctrl, stall, acc, cnt_clr;
    logic [3:0]    op;
    logic          all_busy, any_busy, fill_busy, flush_ok;
    logic          q_push, q_pop, q_empty, q_full;
    logic [BW-1:0] q_head;
    logic          sel_found;
    logic [RW-1:0] sel_idx, rr_next;

    gpu_idx_fifo #(
        .DEPTH (NUM_BUF - 1),
        .W     (BW)
    ) u_wr_queue (
        .clk_i   (gpu_clk),
        .rst_ni  (gpu_rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  (fill_q),
        .data_o  (q_head),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    assign is_ctrl  = (cmd_addr == ADDR_CTRL);
    assign op       = cmd_data[3:0];
    assign all_busy = &raster_busy;
    assign any_busy = |raster_busy;
    assign flush_ok = q_empty && (wstate_q == W_IDLE) && wr_flushed;

    // A buffer cannot be handed to the writer while a raster unit still draws into it.
    always_comb begin
        fill_busy = 1'b0;
        for (int i = 0; i < NUM_RASTER; i++) begin
            if (raster_busy[i] && (rbuf_q[i*BW +: BW] == fill_q)) fill_busy = 1'b1;
        end
    end

    // First idle raster unit, searched round-robin starting at rr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_RASTER; k++) begin
            if (!sel_found && !raster_busy[(int'(rr_q) + k) % NUM_RASTER]) begin
                sel_found = 1'b1;
                sel_idx   = RW'((int'(rr_q) + k) % NUM_RASTER);
            end
        end
        rr_next = (sel_idx == RW'(NUM_RASTER - 1)) ? '0 : sel_idx + 1'b1;
    end

    // Backpressure only ever comes from control commands that cannot finish now.
    always_comb begin
        stall = 1'b0;
        if (is_ctrl) begin
            case (op)
                OP_START_RASTER: stall = all_busy;
                OP_START_WRITE:  stall = fill_busy | q_full;
                OP_WAIT_FLUSH:   stall = !flush_ok;
                OP_FENCE:        stall = any_busy | !flush_ok;
                default:         stall = 1'b0;
            endcase
        end
    end

    assign cmd_ready = !stall;
    assign acc       = cmd_valid && cmd_ready;
    assign cnt_clr   = acc && is_ctrl && (op == OP_RESET_STATE);

    // Command execution: next values for every command-driven register.
    always_comb begin
        fill_d   = fill_q;
        rr_d     = rr_q;
        rstart_d = '0;
        rbuf_d   = rbuf_q;
        clear_d  = clear_q;
        wren_d   = 1'b0;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        q_push   = 1'b0;
        if (acc) begin
            if (is_ctrl) begin
                case (op)
                    OP_START_RASTER: begin
                        rstart_d[sel_idx]               = 1'b1;
                        rbuf_d[int'(sel_idx)*BW +: BW]  = fill_q;
                        rr_d                            = rr_next;
                        clear_d                         = 1'b0;
                    end
                    OP_START_WRITE: begin
                        q_push  = 1'b1;
                        fill_d  = (fill_q == BW'(NUM_BUF - 1)) ? '0 : fill_q + 1'b1;
                        clear_d = 1'b1;
                    end
                    OP_RESET_STATE: clear_d = 1'b1;
                    default: ;
                endcase
            end else if (cmd_addr == ADDR_BASE) begin
                addr_d = cmd_data;
            end else if (cmd_addr == ADDR_STRIDE) begin
                stride_d = cmd_data[15:0];
            end else if (cmd_addr[7:4] == REG_PAGE) begin
                wren_d  = 1'b1;
                raddr_d = cmd_addr[3:0];
                rdata_d = cmd_data;
            end
        end
    end

    // Writer FSM next state; the queue is sampled before this cycle's push.
    always_comb begin
        wstate_d   = wstate_q;
        wr_start_d = 1'b0;
        wr_buf_d   = wr_buf_q;
        q_pop      = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (!q_empty) begin
                    wr_start_d = 1'b1;
                    wr_buf_d   = q_head;
                    q_pop      = 1'b1;
                    wstate_d   = W_LAUNCH;
                end
            end
            W_LAUNCH: if (wr_reading)  wstate_d = W_BUSY;
            W_BUSY:   if (!wr_reading) wstate_d = W_IDLE;
            default:  wstate_d = W_IDLE;
        endcase
    end

    // State registers; reset drops any queued or in-flight write silently.
    always_ff @(posedge gpu_clk or negedge gpu_rst) begin
        if (!gpu_rst) begin
            fill_q     <= '0;
            rr_q       <= '0;
            rstart_q   <= '0;
            rbuf_q     <= '0;
            clear_q    <= 1'b0;
            wren_q     <= 1'b0;
            raddr_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            wr_start_q <= 1'b0;
            wr_buf_q   <= '0;
            wstate_q   <= W_IDLE;
        end else begin
            fill_q     <= fill_d;
            rr_q       <= rr_d;
            rstart_q   <= rstart_d;
            rbuf_q     <= rbuf_d;
            clear_q    <= clear_d;
            wren_q     <= wren_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            wr_start_q <= wr_start_d;
            wr_buf_q   <= wr_buf_d;
            wstate_q   <= wstate_d;
        end
    end

    assign raster_start = rstart_q;
    assign raster_buf   = rbuf_q;
    assign raster_clear = clear_q;
    assign reg_wren     = wren_q;
    assign reg_addr     = raddr_q;
    assign reg_data     = rdata_q;
    assign wr_start     = wr_start_q;
    assign wr_buf       = wr_buf_q;
    assign addr_out     = addr_q;
    assign stride_out   = stride_q;

`ifdef GPU_PERF_COUNTERS_EN
    logic [CNT_W-1:0]    cnt_q [NUM_PERF];
    logic [NUM_PERF-1:0] cnt_inc;

    assign cnt_inc = {cmd_valid & ~cmd_ready, ~cmd_valid, (wstate_q != W_IDLE), any_busy, 1'b1};

    // Counters; a RESET_STATE zeroes them but still counts its own cycle.
    always_ff @(posedge gpu_clk or negedge gpu_rst) begin
        if (!gpu_rst) begin
            for (int k = 0; k < NUM_PERF; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_PERF; k++)
                cnt_q[k] <= (cnt_clr ? '0 : cnt_q[k]) + CNT_W'(cnt_inc[k]);
        end
    end

    // Counter readback mux.
    always_comb begin
        perf_data = '0;
        case (perf_sel)
            3'd0:    perf_data = cnt_q[0];
            3'd1:    perf_data = cnt_q[1];
            3'd2:    perf_data = cnt_q[2];
            3'd3:    perf_data = cnt_q[3];
            3'd4:    perf_data = cnt_q[4];
            default: perf_data = '0;
        endcase
    end
`else
    logic unused_perf;
    assign unused_perf = ^{perf_sel, cnt_clr};
    assign perf_data   = '0;
`endif

endmodule
